// File: rtl/mux_scan_ctrl_if.sv
// Handshake/bus bundle between the 8:1 mux scan sequencer and its user.
// The parity signal exists only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_ctrl_if;
  logic       start;
  logic       hold;
  logic       Y;
  logic       S0;
  logic       S1;
  logic       S2;
  logic       busy;
  logic       done;
  logic [7:0] data_out;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity;
`endif

`ifdef MUX_SCAN_PARITY_EN
  modport master (
    output start, hold, Y,
    input  S0, S1, S2, busy, done, data_out, parity
  );
  modport slave (
    input  start, hold, Y,
    output S0, S1, S2, busy, done, data_out, parity
  );
`else
  modport master (
    output start, hold, Y,
    input  S0, S1, S2, busy, done, data_out
  );
  modport slave (
    input  start, hold, Y,
    output S0, S1, S2, busy, done, data_out
  );
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps an 8:1 mux through codes 0..7, samples Y once per code and publishes the byte.
// Optional feature macro: MUX_SCAN_PARITY_EN adds a registered even-parity output.
module mux_scan_ctrl #(
  parameter int SETTLE = 0
) (
  input  logic            clk,
  input  logic            rst,
  mux_scan_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     r_state;
  logic [2:0] r_sel;
  logic [3:0] r_wcnt;
  logic [7:0] r_cap;
  logic [7:0] r_data;
  logic       r_busy;
  logic       r_done;
  logic [7:0] w_cap_next;
`ifdef MUX_SCAN_PARITY_EN
  logic       r_parity;
`endif

  // Capture word including the bit sampled on this edge, so the final
  // code lands in data_out together with the rest of the byte.
  always_comb begin
    w_cap_next        = r_cap;
    w_cap_next[r_sel] = bus.Y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sel    <= 3'd0;
      r_wcnt   <= 4'd0;
      r_cap    <= 8'h00;
      r_data   <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= SCAN;
            r_sel   <= 3'd0;
            r_wcnt  <= 4'd0;
            r_cap   <= 8'h00;
            r_busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (!bus.hold) begin
            if (r_wcnt != SETTLE_C) begin
              r_wcnt <= r_wcnt + 4'd1;
            end else begin
              r_cap  <= w_cap_next;
              r_wcnt <= 4'd0;
              if (r_sel != 3'd7) begin
                r_sel <= r_sel + 3'd1;
              end else begin
                r_data   <= w_cap_next;
`ifdef MUX_SCAN_PARITY_EN
                r_parity <= ^w_cap_next;
`endif
                r_done   <= 1'b1;
                r_busy   <= 1'b0;
                r_sel    <= 3'd0;
                r_state  <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.S0       = r_sel[0];
  assign bus.S1       = r_sel[1];
  assign bus.S2       = r_sel[2];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.data_out = r_data;
`ifdef MUX_SCAN_PARITY_EN
  assign bus.parity   = r_parity;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: two instances (SETTLE=0 and SETTLE=2) behind behavioural muxes.
// Parity checks are compiled in when MUX_SCAN_PARITY_EN is defined.
module tb_mux_scan_ctrl;
  logic clk;
  logic rst;
  logic [7:0] src0;
  logic [7:0] src2;
  int checks;
  int failures;

  mux_scan_ctrl_if if0 ();
  mux_scan_ctrl_if if2 ();

  mux_scan_ctrl #(.SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mux_scan_ctrl #(.SETTLE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  assign if0.Y = src0[{if0.S2, if0.S1, if0.S0}];
  assign if2.Y = src2[{if2.S2, if2.S1, if2.S0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] sel0();
    return {if0.S2, if0.S1, if0.S0};
  endfunction

  function automatic logic [2:0] sel2();
    return {if2.S2, if2.S1, if2.S0};
  endfunction

  // Full SETTLE=0 scan from IDLE; ends in the done cycle.
  task automatic scan0(input string tag, input logic [7:0] src, input logic [7:0] exp);
    src0 = src;
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_sel"}, 32'(sel0()), 32'(k));
      chk({tag, "_busy"}, 32'(if0.busy), 32'd1);
      chk({tag, "_nodone"}, 32'(if0.done), 32'd0);
      step();
    end
    chk({tag, "_done"}, 32'(if0.done), 32'd1);
    chk({tag, "_busy_low"}, 32'(if0.busy), 32'd0);
    chk({tag, "_data"}, 32'(if0.data_out), 32'(exp));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    src0 = 8'h00;
    src2 = 8'h00;
    if0.start = 1'b0;
    if0.hold = 1'b0;
    if2.start = 1'b0;
    if2.hold = 1'b0;
    rst = 1'b1;
    step();
    step();

    chk("rst_sel", 32'(sel0()), 32'd0);
    chk("rst_busy", 32'(if0.busy), 32'd0);
    chk("rst_done", 32'(if0.done), 32'd0);
    chk("rst_data", 32'(if0.data_out), 32'h00);
`ifdef MUX_SCAN_PARITY_EN
    chk("rst_parity", 32'(if0.parity), 32'd0);
`endif
    rst = 1'b0;
    step();

    // hold in IDLE does nothing
    if0.hold = 1'b1;
    step();
    step();
    chk("idle_hold_busy", 32'(if0.busy), 32'd0);
    chk("idle_hold_sel", 32'(sel0()), 32'd0);
    if0.hold = 1'b0;

    scan0("basic", 8'hA5, 8'hA5);
    step();
    chk("basic_done_once", 32'(if0.done), 32'd0);
    chk("basic_data_hold", 32'(if0.data_out), 32'hA5);

    // SETTLE=2: each code lasts three cycles, done 24 cycles after acceptance
    src2 = 8'h3C;
    if2.start = 1'b1;
    step();
    if2.start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk("settle_sel", 32'(sel2()), 32'(k / 3));
      chk("settle_busy", 32'(if2.busy), 32'd1);
      step();
    end
    chk("settle_done", 32'(if2.done), 32'd1);
    chk("settle_data", 32'(if2.data_out), 32'h3C);
    chk("settle_other_idle", 32'(if0.data_out), 32'hA5);

    // hold three cycles at sel=4
    src0 = 8'hF0;
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("hold_sel_pre", 32'(sel0()), 32'd4);
    if0.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_sel_frozen", 32'(sel0()), 32'd4);
      chk("hold_nodone", 32'(if0.done), 32'd0);
    end
    if0.hold = 1'b0;
    for (int k = 4; k < 8; k++) begin
      chk("hold_sel_post", 32'(sel0()), 32'(k));
      step();
    end
    chk("hold_done", 32'(if0.done), 32'd1);
    chk("hold_data", 32'(if0.data_out), 32'hF0);

    // start held high: ignored while busy, re-accepted in the done cycle
    step();
    src0 = 8'h81;
    if0.start = 1'b1;
    step();
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 8; k++) begin
        chk("cont_sel", 32'(sel0()), 32'(k));
        chk("cont_busy", 32'(if0.busy), 32'd1);
        step();
      end
      chk("cont_done", 32'(if0.done), 32'd1);
      chk("cont_data", 32'(if0.data_out), 32'h81);
      if (rep == 1) if0.start = 1'b0;
      step();
    end
    chk("cont_idle_busy", 32'(if0.busy), 32'd0);
    chk("cont_idle_done", 32'(if0.done), 32'd0);

    // reset mid-scan
    scan0("pre_rst", 8'h5A, 8'h5A);
    step();
    src0 = 8'hFF;
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    step();
    step();
    step();
    chk("mid_sel3", 32'(sel0()), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_sel", 32'(sel0()), 32'd0);
    chk("mid_rst_busy", 32'(if0.busy), 32'd0);
    chk("mid_rst_data", 32'(if0.data_out), 32'h00);
    chk("mid_rst_done", 32'(if0.done), 32'd0);
    step();
    chk("mid_rst_done2", 32'(if0.done), 32'd0);
    chk("mid_rst_busy2", 32'(if0.busy), 32'd0);
    scan0("post_rst", 8'hFF, 8'hFF);
    step();

`ifdef MUX_SCAN_PARITY_EN
    scan0("par07", 8'h07, 8'h07);
    chk("par07_parity", 32'(if0.parity), 32'd1);
    step();
    scan0("par0f", 8'h0F, 8'h0F);
    chk("par0f_parity", 32'(if0.parity), 32'd0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
